// File: rtl/fpaddsub_round_module.sv
// Final rounding stage of the binary32 add/sub datapath: applies the selected
// IEEE-754 rounding mode to a normalized result and registers Z/Inexact.
module fpaddsub_round_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        Sgn,
    input  logic [7:0]  NormE,
    input  logic [22:0] NormM,
    input  logic        R,
    input  logic        S,
    input  logic [1:0]  RoundMode,
    output logic [31:0] Z,
    output logic        Inexact,
    output logic        out_valid
);

    localparam logic [1:0] RndNearEven = 2'b00;
    localparam logic [1:0] RndZero     = 2'b01;
    localparam logic [1:0] RndPosInf   = 2'b10;
    localparam logic [1:0] RndNegInf   = 2'b11;

    logic        inc;
    logic [23:0] mantSum;
    logic        mantCarry;
    logic [7:0]  roundE;
    logic [22:0] roundM;
    logic        isSpecial;
    logic [31:0] zNext;
    logic        inexactNext;

    always_comb begin
        inc = 1'b0;
        unique case (RoundMode)
            RndNearEven: inc = R & (S | NormM[0]);
            RndZero:     inc = 1'b0;
            RndPosInf:   inc = ~Sgn & (R | S);
            RndNegInf:   inc = Sgn & (R | S);
            default:     inc = 1'b0;
        endcase
    end

    // A carry out of the fraction renormalizes to 1.0 x 2^(E+1); from E=254
    // this lands on exponent 255 with zero fraction, i.e. infinity.
    always_comb begin
        mantSum   = {1'b0, NormM} + {23'd0, inc};
        mantCarry = mantSum[23];
        roundE    = mantCarry ? (NormE + 8'd1) : NormE;
        roundM    = mantCarry ? 23'd0 : mantSum[22:0];
    end

    // Inf/NaN operands are already fully formed and pass through untouched.
    always_comb begin
        isSpecial = (NormE == 8'hFF);
        if (isSpecial) begin
            zNext       = {Sgn, NormE, NormM};
            inexactNext = 1'b0;
        end else begin
            zNext       = {Sgn, roundE, roundM};
            inexactNext = R | S;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Z         <= 32'h0;
            Inexact   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Z       <= zNext;
                Inexact <= inexactNext;
            end
        end
    end

endmodule

// File: tb/tb_fpaddsub_round_module.sv
// Directed-vector bench for the binary32 rounding stage; expected results are
// hand-computed constants.
module tb_fpaddsub_round_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        Sgn;
    logic [7:0]  NormE;
    logic [22:0] NormM;
    logic        R;
    logic        S;
    logic [1:0]  RoundMode;
    logic [31:0] Z;
    logic        Inexact;
    logic        out_valid;

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    fpaddsub_round_module dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Sgn       (Sgn),
        .NormE     (NormE),
        .NormM     (NormM),
        .R         (R),
        .S         (S),
        .RoundMode (RoundMode),
        .Z         (Z),
        .Inexact   (Inexact),
        .out_valid (out_valid)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nBad++;
            $display("FAIL %s got=%h want=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after
    // the next rising edge.
    task automatic step(input logic rstV, input logic vld, input logic sg, input logic [7:0] e,
                        input logic [22:0] m, input logic r, input logic s, input logic [1:0] mode);
        @(negedge clk);
        rst       = rstV;
        in_valid  = vld;
        Sgn       = sg;
        NormE     = e;
        NormM     = m;
        R         = r;
        S         = s;
        RoundMode = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic sg, input logic [7:0] e, input logic [22:0] m,
                       input logic r, input logic s, input logic [1:0] mode,
                       input logic [31:0] expZ, input logic expInx);
        step(1'b0, 1'b1, sg, e, m, r, s, mode);
        checkVal({tag, ".Z"}, Z, expZ);
        checkVal({tag, ".inx"}, {31'd0, Inexact}, {31'd0, expInx});
        checkVal({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; Sgn = 1'b0; NormE = 8'h0; NormM = 23'h0;
        R = 1'b0; S = 1'b0; RoundMode = 2'b00;

        // reset wins over a valid operand on the same edge
        step(1'b1, 1'b1, 1'b0, 8'h7F, 23'h000001, 1'b1, 1'b1, 2'b00);
        checkVal("rst.Z", Z, 32'h0);
        checkVal("rst.inx", {31'd0, Inexact}, 32'd0);
        checkVal("rst.ov", {31'd0, out_valid}, 32'd0);

        // first op right after reset, no warm-up
        vec("tieOdd",   1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 2'b00, 32'h3F800002, 1'b1);
        vec("tieEven",  1'b0, 8'h7F, 23'h000000, 1'b1, 1'b0, 2'b00, 32'h3F800000, 1'b1);
        vec("nearUp",   1'b0, 8'h7F, 23'h000000, 1'b1, 1'b1, 2'b00, 32'h3F800001, 1'b1);
        vec("nearDn",   1'b0, 8'h7F, 23'h000000, 1'b0, 1'b1, 2'b00, 32'h3F800000, 1'b1);
        vec("carry",    1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 1'b1, 2'b00, 32'h40000000, 1'b1);
        vec("ovfNear",  1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 32'h7F800000, 1'b1);
        vec("ovfZero",  1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 2'b01, 32'h7F7FFFFF, 1'b1);
        vec("negNinf",  1'b1, 8'h80, 23'h000000, 1'b0, 1'b1, 2'b11, 32'hC0000001, 1'b1);
        vec("negPinf",  1'b1, 8'h80, 23'h000000, 1'b0, 1'b1, 2'b10, 32'hC0000000, 1'b1);
        vec("posPinf",  1'b0, 8'h7F, 23'h000000, 1'b0, 1'b1, 2'b10, 32'h3F800001, 1'b1);
        vec("posNinf",  1'b0, 8'h7F, 23'h000000, 1'b1, 1'b1, 2'b11, 32'h3F800000, 1'b1);
        vec("truncRS",  1'b0, 8'h7F, 23'h000005, 1'b1, 1'b1, 2'b01, 32'h3F800005, 1'b1);
        vec("exact",    1'b1, 8'h85, 23'h123456, 1'b0, 1'b0, 2'b10, 32'hC2923456, 1'b0);
        vec("exactNe",  1'b0, 8'h85, 23'h123457, 1'b0, 1'b0, 2'b00, 32'h42923457, 1'b0);
        vec("nanPass",  1'b0, 8'hFF, 23'h400000, 1'b1, 1'b1, 2'b00, 32'h7FC00000, 1'b0);
        vec("infPass",  1'b1, 8'hFF, 23'h000000, 1'b1, 1'b0, 2'b11, 32'hFF800000, 1'b0);
        vec("subCarry", 1'b0, 8'h00, 23'h7FFFFF, 1'b1, 1'b0, 2'b00, 32'h00800000, 1'b1);
        vec("subRound", 1'b1, 8'h00, 23'h000002, 1'b1, 1'b0, 2'b11, 32'h80000003, 1'b1);

        // idle cycle: outputs hold, out_valid drops
        step(1'b0, 1'b0, 1'b0, 8'h10, 23'h0, 1'b1, 1'b1, 2'b00);
        checkVal("hold.Z", Z, 32'h80000003);
        checkVal("hold.inx", {31'd0, Inexact}, 32'd1);
        checkVal("hold.ov", {31'd0, out_valid}, 32'd0);

        // reset mid-stream on back-to-back operands
        vec("strmA", 1'b0, 8'h40, 23'h000010, 1'b0, 1'b1, 2'b00, 32'h20000010, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h41, 23'h000020, 1'b1, 1'b1, 2'b11);
        checkVal("strmRst.Z", Z, 32'h0);
        checkVal("strmRst.inx", {31'd0, Inexact}, 32'd0);
        checkVal("strmRst.ov", {31'd0, out_valid}, 32'd0);
        vec("strmC", 1'b0, 8'h42, 23'h000030, 1'b0, 1'b0, 2'b00, 32'h21000030, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0, 2'b00);
        checkVal("strmEnd.Z", Z, 32'h21000030);
        checkVal("strmEnd.ov", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
